// File: rtl/brush_stamp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : brush_stamp_sequencer
//  Description : Expands one paint request at the cursor into a stream of
//                framebuffer pixel writes. The stream covers the square brush
//                footprint and its symmetry mirrors, one candidate pixel per
//                cycle, through a registered valid/ready write slot.
//  Ports       : clk, rst (async, active-high)
//                stamp_req, cursor_x, cursor_y, brush_size, symmetry_mode,
//                color                 - request side, sampled in IDLE only
//                pix_valid/pix_ready, pix_x, pix_y, pix_color - write port
//                busy (GEN or DONE), done (one-cycle completion pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module brush_stamp_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COORD_W  = 8,
    parameter int COLOR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stamp_req,
    input  logic [COORD_W-1:0] cursor_x,
    input  logic [COORD_W-1:0] cursor_y,
    input  logic [2:0]         brush_size,
    input  logic [1:0]         symmetry_mode,
    input  logic [COLOR_W-1:0] color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_GEN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Clip limits carry one extra bit so cursor + offset never wraps.
    localparam logic [COORD_W:0]   c_W_EXT = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0]   c_H_EXT = (COORD_W+1)'(SCREEN_H);
    localparam logic [COORD_W-1:0] c_XMAX  = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] c_YMAX  = COORD_W'(SCREEN_H - 1);

    logic [1:0]         r_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [2:0]         r_size;
    logic [1:0]         r_sym;
    logic [COLOR_W-1:0] r_color;
    logic [2:0]         r_dx;
    logic [2:0]         r_dy;
    logic [1:0]         r_m;
    logic               r_gen_done;   // every candidate has been issued or dropped
    logic               r_pix_valid;
    logic [COORD_W-1:0] r_pix_x;
    logic [COORD_W-1:0] r_pix_y;
    logic [COLOR_W-1:0] r_pix_color;
    logic               r_busy;
    logic               r_done;

    logic [COORD_W:0]   w_bx_wide;
    logic [COORD_W:0]   w_by_wide;
    logic [COORD_W-1:0] w_bx;
    logic [COORD_W-1:0] w_by;
    logic [COORD_W-1:0] w_cand_x;
    logic [COORD_W-1:0] w_cand_y;
    logic               w_in_range;
    logic               w_last_m;
    logic               w_last_dx;
    logic               w_last_dy;
    logic               w_last_cand;
    logic [1:0]         w_m_next;
    logic               w_hs;
    logic               w_slot_free;

    // Candidate generation: clip test on the unmirrored point, then mirror.
    always_comb begin
        w_bx_wide  = {1'b0, r_x} + (COORD_W+1)'(r_dx);
        w_by_wide  = {1'b0, r_y} + (COORD_W+1)'(r_dy);
        w_in_range = (w_bx_wide < c_W_EXT) && (w_by_wide < c_H_EXT);
        w_bx       = w_bx_wide[COORD_W-1:0];
        w_by       = w_by_wide[COORD_W-1:0];
        w_cand_x   = r_m[0] ? (c_XMAX - w_bx) : w_bx;
        w_cand_y   = r_m[1] ? (c_YMAX - w_by) : w_by;
    end

    // Mirror sequence per mode: {0}, {0,1}, {0,2}, {0,1,2,3}. The final
    // mirror index of each mode equals the mode value itself, and the only
    // non-final successor of 0 is the mode value (or m+1 in 4-way).
    always_comb begin
        w_last_m    = (r_m == r_sym);
        w_last_dx   = (r_dx == r_size);
        w_last_dy   = (r_dy == r_size);
        w_last_cand = w_last_m && w_last_dx && w_last_dy;
        w_m_next    = (r_sym == 2'd3) ? (r_m + 2'd1) : r_sym;
        w_hs        = r_pix_valid && pix_ready;
        w_slot_free = !r_pix_valid || w_hs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_size      <= '0;
            r_sym       <= '0;
            r_color     <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_m         <= '0;
            r_gen_done  <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_color <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_pix_valid <= 1'b0;
                    if (stamp_req) begin
                        r_x        <= cursor_x;
                        r_y        <= cursor_y;
                        r_size     <= brush_size;
                        r_sym      <= symmetry_mode;
                        r_color    <= color;
                        r_dx       <= '0;
                        r_dy       <= '0;
                        r_m        <= '0;
                        r_gen_done <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_ST_GEN;
                    end
                end

                c_ST_GEN: begin
                    if (!r_gen_done) begin
                        if (w_slot_free) begin
                            if (w_in_range) begin
                                r_pix_valid <= 1'b1;
                                r_pix_x     <= w_cand_x;
                                r_pix_y     <= w_cand_y;
                                r_pix_color <= r_color;
                            end else begin
                                // Dropped candidate: slot stays/becomes empty.
                                r_pix_valid <= 1'b0;
                            end

                            if (!w_last_m) begin
                                r_m <= w_m_next;
                            end else begin
                                r_m <= '0;
                                if (!w_last_dx) begin
                                    r_dx <= r_dx + 3'd1;
                                end else begin
                                    r_dx <= '0;
                                    r_dy <= r_dy + 3'd1;
                                end
                            end

                            if (w_last_cand) begin
                                if (w_in_range) begin
                                    r_gen_done <= 1'b1;
                                end else begin
                                    // Last candidate clipped and slot now empty.
                                    r_state <= c_ST_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end else if (w_hs || !r_pix_valid) begin
                        r_pix_valid <= 1'b0;
                        r_state     <= c_ST_DONE;
                        r_done      <= 1'b1;
                    end
                end

                c_ST_DONE: begin
                    r_pix_valid <= 1'b0;
                    r_gen_done  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end

                default: begin
                    r_pix_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign pix_valid = r_pix_valid;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_color = r_pix_color;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_brush_stamp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brush_stamp_sequencer
//  Description : Directed scoreboard bench for brush_stamp_sequencer. Stimulus
//                pushes hand-computed pixels into a queue; a monitor pops and
//                compares on every write-port handshake and checks that the
//                slot is held stable under backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brush_stamp_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stamp_req = 1'b0;
    logic [7:0] cursor_x = '0;
    logic [7:0] cursor_y = '0;
    logic [2:0] brush_size = '0;
    logic [1:0] symmetry_mode = '0;
    logic [3:0] color = '0;
    logic       pix_valid;
    logic       pix_ready = 1'b1;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [3:0] pix_color;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    brush_stamp_sequencer #(
        .SCREEN_W(160), .SCREEN_H(120), .COORD_W(8), .COLOR_W(4)
    ) dut (
        .clk(clk), .rst(rst), .stamp_req(stamp_req),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .brush_size(brush_size), .symmetry_mode(symmetry_mode),
        .color(color), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   hs_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int c);
        pix_t p;
        p.x = 8'(x);
        p.y = 8'(y);
        p.c = 4'(c);
        exp_q.push_back(p);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    pix_t held;
    logic stalled = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 32'(pix_valid), 32'd1);
                check("hold_pixel", 32'({pix_x, pix_y, pix_color}), 32'(held));
            end
            if (pix_valid && pix_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pixel: got %0d,%0d,%0d expected none", pix_x, pix_y, pix_color);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("pixel", 32'({pix_x, pix_y, pix_color}), 32'(e));
                end
            end
            stalled = pix_valid && !pix_ready;
            held    = {pix_x, pix_y, pix_color};
        end
    end

    // Called at posedge+1; the next posedge is the request edge E0.
    task automatic start_stamp(input int x, input int y, input int size, input int sym, input int c);
        cursor_x      = 8'(x);
        cursor_y      = 8'(y);
        brush_size    = 3'(size);
        symmetry_mode = 2'(sym);
        color         = 4'(c);
        stamp_req     = 1'b1;
        @(posedge clk);
        #1;
        stamp_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_busy_clear"}, 32'(busy), 32'd0);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic t1_run(input string name);
        hs_count = 0;
        push(10, 20, 5);
        start_stamp(10, 20, 0, 0, 5);
        check({name, "_e0_busy"}, 32'(busy), 32'd1);
        check({name, "_e0_valid"}, 32'(pix_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_e1_valid"}, 32'(pix_valid), 32'd1);
        check({name, "_e1_pixel"}, 32'({pix_x, pix_y, pix_color}), {12'd0, 8'd10, 8'd20, 4'd5});
        @(posedge clk); #1;
        check({name, "_e2_valid"}, 32'(pix_valid), 32'd0);
        check({name, "_e2_done"}, 32'(done), 32'd1);
        check({name, "_e2_busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({name, "_e3_done"}, 32'(done), 32'd0);
        check({name, "_e3_busy"}, 32'(busy), 32'd0);
        check({name, "_handshakes"}, 32'(hs_count), 32'd1);
    endtask

    task automatic push_t2(input int c);
        push(0, 0, c);   push(159, 0, c);   push(0, 119, c);   push(159, 119, c);
        push(1, 0, c);   push(158, 0, c);   push(1, 119, c);   push(158, 119, c);
        push(0, 1, c);   push(159, 1, c);   push(0, 118, c);   push(159, 118, c);
        push(1, 1, c);   push(158, 1, c);   push(1, 118, c);   push(158, 118, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_pixel", 32'({pix_x, pix_y, pix_color}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: single pixel with exact cycle timing
        t1_run("t1");

        // T2: 4-way symmetry at the origin
        hs_count = 0;
        push_t2(9);
        start_stamp(0, 0, 1, 3, 9);
        wait_done("t2");
        check("t2_handshakes", 32'(hs_count), 32'd16);

        // T3: clipping at the bottom-right corner
        hs_count = 0;
        push(158, 118, 3); push(159, 118, 3); push(158, 119, 3); push(159, 119, 3);
        start_stamp(158, 118, 2, 0, 3);
        wait_done("t3");
        check("t3_handshakes", 32'(hs_count), 32'd4);

        // T4: backpressure mid-stream
        hs_count = 0;
        push_t2(6);
        start_stamp(0, 0, 1, 3, 6);
        repeat (3) begin @(posedge clk); #1; end
        pix_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("t4_stalled_valid", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        wait_done("t4");
        check("t4_handshakes", 32'(hs_count), 32'd16);

        // T5: request and inputs changing during GEN are ignored
        hs_count = 0;
        push(30, 40, 7); push(129, 40, 7);
        start_stamp(30, 40, 0, 1, 7);
        pix_ready     = 1'b0;
        stamp_req     = 1'b1;
        brush_size    = 3'd7;
        cursor_x      = 8'd1;
        cursor_y      = 8'd1;
        symmetry_mode = 2'd3;
        color         = 4'd0;
        repeat (3) begin @(posedge clk); #1; end
        stamp_req = 1'b0;
        pix_ready = 1'b1;
        wait_done("t5a");
        repeat (3) begin @(posedge clk); #1; end
        check("t5_not_queued", 32'(busy), 32'd0);
        check("t5a_handshakes", 32'(hs_count), 32'd2);
        hs_count = 0;
        push(5, 6, 2); push(5, 113, 2);
        start_stamp(5, 6, 0, 2, 2);
        wait_done("t5b");
        check("t5b_handshakes", 32'(hs_count), 32'd2);

        // T6: asynchronous reset in the middle of a stamp
        push_t2(9);
        start_stamp(0, 0, 1, 3, 9);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(pix_valid), 32'd0);
        check("t6_busy",  32'(busy), 32'd0);
        check("t6_done",  32'(done), 32'd0);
        check("t6_pixel", 32'({pix_x, pix_y, pix_color}), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        t1_run("t6_t1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
